// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
//  cache_pkg
//  Shared constants and types for the cache-side CPU bus ports: bus widths,
//  C1_*/C2_* opcodes, address field widths, port FSM states and the request
//  record passed to the cache core.
//  Revision: 1.0 - initial release
// ============================================================================
package cache_pkg;

   // Address field widths
   localparam int CACHE_TAG_SIZE    = 10;
   localparam int CACHE_SET_SIZE    = 5;
   localparam int CACHE_OFFSET_SIZE = 4;
   localparam int CACHE_ADDR_W      = CACHE_TAG_SIZE + CACHE_SET_SIZE + CACHE_OFFSET_SIZE;

   // Bus 1 widths
   localparam int C1_W = 3;
   localparam int A1_W = CACHE_TAG_SIZE + CACHE_SET_SIZE;
   localparam int D1_W = 16;

   // Bus 1 opcodes (RESPONSE shares the encoding of WRITE32; direction tells them apart)
   localparam logic [C1_W-1:0] C1_NOP             = 3'd0;
   localparam logic [C1_W-1:0] C1_READ8           = 3'd1;
   localparam logic [C1_W-1:0] C1_READ16          = 3'd2;
   localparam logic [C1_W-1:0] C1_READ32          = 3'd3;
   localparam logic [C1_W-1:0] C1_INVALIDATE_LINE = 3'd4;
   localparam logic [C1_W-1:0] C1_WRITE8          = 3'd5;
   localparam logic [C1_W-1:0] C1_WRITE16         = 3'd6;
   localparam logic [C1_W-1:0] C1_WRITE32         = 3'd7;
   localparam logic [C1_W-1:0] C1_RESPONSE        = 3'd7;

   // Bus 2 opcodes (memory side)
   localparam logic [1:0] C2_NOP        = 2'd0;
   localparam logic [1:0] C2_READ_LINE  = 2'd1;
   localparam logic [1:0] C2_WRITE_LINE = 2'd2;
   localparam logic [1:0] C2_RESPONSE   = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ADDR2     = 3'd1,
      ST_TURN      = 3'd2,
      ST_WAIT_CORE = 3'd3,
      ST_RESP1     = 3'd4,
      ST_RESP2     = 3'd5,
      ST_RELEASE   = 3'd6
   } port_state_e;

   typedef struct packed {
      logic [C1_W-1:0]         cmd;
      logic [CACHE_ADDR_W-1:0] addr;
      logic [31:0]             wdata;
   } cache_req_t;

   function automatic logic is_read(input logic [C1_W-1:0] cmd);
      return (cmd == C1_READ8) || (cmd == C1_READ16) || (cmd == C1_READ32);
   endfunction

   function automatic logic is_write(input logic [C1_W-1:0] cmd);
      return (cmd == C1_WRITE8) || (cmd == C1_WRITE16) || (cmd == C1_WRITE32);
   endfunction

endpackage
`default_nettype wire

// File: rtl/tri_drv.sv
`default_nettype none
// ============================================================================
//  tri_drv
//  Output-enable gated tri-state driver for a shared bus.
//  Ports:
//     oe  - drive enable; pad floats (Z) when low
//     din - value driven onto the pad while oe is high
//     pad - shared bus net
//  Revision: 1.0 - initial release
// ============================================================================
module tri_drv #(
   parameter int W = 1
) (
   input  logic         oe,
   input  logic [W-1:0] din,
   inout  wire  [W-1:0] pad
);

   assign pad = oe ? din : {W{1'bz}};

endmodule
`default_nettype wire

// File: rtl/cache_c1_port.sv
`default_nettype none
// ============================================================================
//  cache_c1_port
//  Cache-side slave for CPU bus 1. Decodes the two-tick C1/A1/D1 request,
//  hands it to the cache core over core_req/core_ack, then returns the result
//  as C1_RESPONSE beats on D1 before releasing the bus.
//  Ports:
//     clk, reset          - clock; asynchronous active-high reset
//     C1, A1, D1          - bus 1 command (inout), address (in), data (inout)
//     core_req/cmd/addr/wdata - decoded request to the core, held until ack
//     core_ack, core_rdata    - core completion pulse and read result
//     busy                - high whenever the port is not idle
//     req_cnt, rd_cnt     - request / read counters (CACHE_C1_PORT_STATS_EN)
//  Optional feature macro: CACHE_C1_PORT_STATS_EN
//  Revision: 1.0 - initial release
// ============================================================================
module cache_c1_port
   import cache_pkg::*;
#(
   parameter int TAG_W  = CACHE_TAG_SIZE,
   parameter int SET_W  = CACHE_SET_SIZE,
   parameter int OFF_W  = CACHE_OFFSET_SIZE,
   parameter int ADDR_W = TAG_W + SET_W + OFF_W
) (
   input  logic                    clk,
   input  logic                    reset,
   inout  wire  [C1_W-1:0]         C1,
   input  logic [TAG_W+SET_W-1:0]  A1,
   inout  wire  [D1_W-1:0]         D1,
   output logic                    core_req,
   output logic [C1_W-1:0]         core_cmd,
   output logic [ADDR_W-1:0]       core_addr,
   output logic [31:0]             core_wdata,
   input  logic                    core_ack,
   input  logic [31:0]             core_rdata,
   output logic                    busy
`ifdef CACHE_C1_PORT_STATS_EN
   ,
   output logic [31:0]             req_cnt,
   output logic [31:0]             rd_cnt
`endif
);

   port_state_e       state;
   cache_req_t        req;
   logic              c1_oe;
   logic              d1_oe;
   logic [C1_W-1:0]   c1_out;
   logic [D1_W-1:0]   d1_out;
   logic [15:0]       rdata_hi;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         req      <= '0;
         core_req <= 1'b0;
         c1_oe    <= 1'b0;
         d1_oe    <= 1'b0;
         c1_out   <= C1_NOP;
         d1_out   <= '0;
         rdata_hi <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               // An undriven or unknown C1 compares false here and keeps us idle.
               if (C1 != C1_NOP) begin
                  req.cmd   <= C1;
                  req.addr  <= {A1, {OFF_W{1'b0}}};
                  req.wdata <= is_write(C1) ? {16'h0000, D1} : 32'h0;
                  state     <= ST_ADDR2;
               end
            end
            ST_ADDR2: begin
               req.addr[OFF_W-1:0] <= A1[OFF_W-1:0];
               if (req.cmd == C1_WRITE32)
                  req.wdata[31:16] <= D1;
               state <= ST_TURN;
            end
            ST_TURN: begin
               // Bus turnaround done: take C1 (driving NOP) and present the request.
               c1_oe    <= 1'b1;
               c1_out   <= C1_NOP;
               core_req <= 1'b1;
               state    <= ST_WAIT_CORE;
            end
            ST_WAIT_CORE: begin
               if (core_ack) begin
                  core_req <= 1'b0;
                  c1_out   <= C1_RESPONSE;
                  d1_oe    <= is_read(req.cmd);
                  d1_out   <= (req.cmd == C1_READ8) ? {8'h00, core_rdata[7:0]}
                                                    : core_rdata[15:0];
                  rdata_hi <= core_rdata[31:16];
                  state    <= ST_RESP1;
               end
            end
            ST_RESP1: begin
               if (req.cmd == C1_READ32) begin
                  d1_out <= rdata_hi;
                  state  <= ST_RESP2;
               end else begin
                  c1_oe <= 1'b0;
                  d1_oe <= 1'b0;
                  state <= ST_RELEASE;
               end
            end
            ST_RESP2: begin
               c1_oe <= 1'b0;
               d1_oe <= 1'b0;
               state <= ST_RELEASE;
            end
            ST_RELEASE: state <= ST_IDLE;
            default:    state <= ST_IDLE;
         endcase
      end
   end

   assign busy       = (state != ST_IDLE);
   assign core_cmd   = req.cmd;
   assign core_addr  = req.addr;
   assign core_wdata = req.wdata;

`ifdef CACHE_C1_PORT_STATS_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_cnt <= '0;
         rd_cnt  <= '0;
      end else if (state == ST_ADDR2) begin
         req_cnt <= req_cnt + 32'd1;
         if (is_read(req.cmd))
            rd_cnt <= rd_cnt + 32'd1;
      end
   end
`endif

   tri_drv #(.W(C1_W)) u_c1_drv (
      .oe  (c1_oe),
      .din (c1_out),
      .pad (C1)
   );

   tri_drv #(.W(D1_W)) u_d1_drv (
      .oe  (d1_oe),
      .din (d1_out),
      .pad (D1)
   );

endmodule
`default_nettype wire

// File: tb/tb_cache_c1_port.sv
`default_nettype none
// ============================================================================
//  tb_cache_c1_port
//  Self-checking bench for cache_c1_port. C1 is pulled low and D1 pulled high
//  so a released bus reads as NOP / 16'hFFFF. A transaction-level model turns
//  each request into a per-cycle list of expected outputs that one compare
//  process checks at every falling edge; directed cases add literal checks.
//  Optional feature macro: CACHE_C1_PORT_STATS_EN
//  Revision: 1.0 - initial release
// ============================================================================
module tb_cache_c1_port;

   localparam logic [2:0] OP_READ8  = 3'd1;
   localparam logic [2:0] OP_READ16 = 3'd2;
   localparam logic [2:0] OP_READ32 = 3'd3;
   localparam logic [2:0] OP_INVAL  = 3'd4;
   localparam logic [2:0] OP_WR16   = 3'd6;
   localparam logic [2:0] OP_WR32   = 3'd7;
   localparam logic [2:0] OP_RESP   = 3'd7;

   typedef struct {
      bit          busy;
      bit          req;
      bit          chk_c1;
      logic [2:0]  c1;
      bit          chk_d1;
      logic [15:0] d1;
      bit          chk_core;
      logic [2:0]  cmd;
      logic [18:0] addr;
      logic [31:0] wdata;
      logic [31:0] wmask;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   tri0 [2:0]   C1;
   tri1 [15:0]  D1;
   logic [2:0]  c1_drv = 3'd0;
   logic        c1_oe = 1'b0;
   logic [15:0] d1_drv = 16'd0;
   logic        d1_oe = 1'b0;
   logic [14:0] A1 = 15'd0;
   logic        core_ack = 1'b0;
   logic [31:0] core_rdata = 32'd0;
   logic        core_req;
   logic [2:0]  core_cmd;
   logic [18:0] core_addr;
   logic [31:0] core_wdata;
   logic        busy;
`ifdef CACHE_C1_PORT_STATS_EN
   logic [31:0] req_cnt;
   logic [31:0] rd_cnt;
`endif

   assign C1 = c1_oe ? c1_drv : 3'bzzz;
   assign D1 = d1_oe ? d1_drv : 16'hzzzz;

   cache_c1_port dut (
      .clk        (clk),
      .reset      (reset),
      .C1         (C1),
      .A1         (A1),
      .D1         (D1),
      .core_req   (core_req),
      .core_cmd   (core_cmd),
      .core_addr  (core_addr),
      .core_wdata (core_wdata),
      .core_ack   (core_ack),
      .core_rdata (core_rdata),
      .busy       (busy)
`ifdef CACHE_C1_PORT_STATS_EN
      ,
      .req_cnt    (req_cnt),
      .rd_cnt     (rd_cnt)
`endif
   );

   always #5 clk = ~clk;

   int   errors = 0;
   int   checks = 0;
   bit   mon_en = 1'b0;
   int   model_req = 0;
   int   model_rd = 0;
   exp_t exp_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input bit b, input bit r, input bit cc, input logic [2:0] c,
                               input bit cd, input logic [15:0] d);
      exp_t e;
      e.busy = b; e.req = r; e.chk_c1 = cc; e.c1 = c; e.chk_d1 = cd; e.d1 = d;
      e.chk_core = 1'b0; e.cmd = '0; e.addr = '0; e.wdata = '0; e.wmask = '0;
      return e;
   endfunction

   // Expected per-cycle behaviour of one request, starting with the cycle after tick 1.
   function automatic void model_txn(input logic [2:0] cmd, input logic [14:0] a, input logic [14:0] b,
                                     input logic [15:0] da, input logic [15:0] db,
                                     input logic [31:0] rd, input int d);
      exp_t        e;
      logic [15:0] beats[$];
      bit          rdop = (cmd >= 3'd1) && (cmd <= 3'd3);
      bit          wrop = (cmd >= 3'd5);
      if (cmd == OP_READ8)  beats.push_back({8'h00, rd[7:0]});
      else if (rdop)        beats.push_back(rd[15:0]);
      if (cmd == OP_READ32) beats.push_back(rd[31:16]);
      if (!rdop)            beats.push_back(16'hFFFF);
      model_req++;
      if (rdop) model_rd++;
      exp_q.push_back(mk(1, 0, 0, 3'd0, 0, 16'h0));        // second address tick
      exp_q.push_back(mk(1, 0, 1, 3'd0, 0, 16'h0));        // turnaround
      for (int i = 0; i <= d; i++) begin
         e = mk(1, 1, 1, 3'd0, 1, 16'hFFFF);
         e.chk_core = 1'b1;
         e.cmd      = cmd;
         e.addr     = {a, b[3:0]};
         e.wdata    = {db, da};
         e.wmask    = (cmd == OP_WR32) ? 32'hFFFF_FFFF : (wrop ? 32'h0000_FFFF : 32'h0);
         exp_q.push_back(e);
      end
      foreach (beats[i]) exp_q.push_back(mk(1, 0, 1, OP_RESP, 1, beats[i]));
      exp_q.push_back(mk(1, 0, 1, 3'd0, 1, 16'hFFFF));     // release
   endfunction

   // Compare process
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = mk(0, 0, 1, 3'd0, 1, 16'hFFFF);
            chk("busy", {31'd0, busy}, {31'd0, e.busy});
            chk("core_req", {31'd0, core_req}, {31'd0, e.req});
            if (e.chk_c1) chk("C1", {29'd0, C1}, {29'd0, e.c1});
            if (e.chk_d1) chk("D1", {16'd0, D1}, {16'd0, e.d1});
            if (e.chk_core) begin
               chk("core_cmd", {29'd0, core_cmd}, {29'd0, e.cmd});
               chk("core_addr", {13'd0, core_addr}, {13'd0, e.addr});
               chk("core_wdata", core_wdata & e.wmask, e.wdata & e.wmask);
            end
         end
      end
   end

   task automatic run_txn(input logic [2:0] cmd, input logic [14:0] a, input logic [14:0] b,
                          input logic [15:0] da, input logic [15:0] db, input logic [31:0] rd,
                          input int d,
                          output logic [2:0] cap_cmd, output logic [18:0] cap_addr,
                          output logic [31:0] cap_wdata, output logic [15:0] b1,
                          output logic [15:0] b2, output int n_resp, output logic busy_end);
      model_txn(cmd, a, b, da, db, rd, d);
      cap_cmd = '0; cap_addr = '0; cap_wdata = '0; busy_end = 1'b1;
      c1_drv = cmd; c1_oe = 1'b1; A1 = a; d1_drv = da; d1_oe = 1'b1;
      @(negedge clk); #1;
      c1_oe = 1'b0; A1 = b; d1_drv = db;
      @(negedge clk); #1;
      d1_oe = 1'b0; A1 = 15'($urandom);
      for (int j = 0; j <= d; j++) begin
         @(negedge clk); #1;
         if (j == 0) begin cap_cmd = core_cmd; cap_addr = core_addr; cap_wdata = core_wdata; end
         if (j == d) begin core_ack = 1'b1; core_rdata = rd; end
      end
      n_resp = 0; b1 = '0; b2 = '0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); #1;
         if (k == 0) begin core_ack = 1'b0; core_rdata = $urandom; end
         if (C1 == OP_RESP) n_resp++;
         if (k == 0) b1 = D1;
         if (k == 1) b2 = D1;
         if (k == 3) busy_end = busy;
      end
   endtask

   // Starts a READ16 and hits reset in WAIT_CORE (at_resp=0) or in RESP1 (at_resp=1).
   task automatic reset_txn(input bit at_resp);
      model_txn(OP_READ16, 15'h1234, 15'h0005, 16'h0, 16'h0, 32'h0000_9876, at_resp ? 0 : 6);
      c1_drv = OP_READ16; c1_oe = 1'b1; A1 = 15'h1234; d1_drv = 16'h0; d1_oe = 1'b1;
      @(negedge clk); #1;
      c1_oe = 1'b0; A1 = 15'h0005;
      @(negedge clk); #1;
      d1_oe = 1'b0;
      @(negedge clk); #1;
      chk("rst_pre_core_req", {31'd0, core_req}, 32'd1);
      if (at_resp) begin
         core_ack = 1'b1; core_rdata = 32'h0000_9876;
         @(negedge clk); #1;
         core_ack = 1'b0;
         chk("rst_pre_C1", {29'd0, C1}, {29'd0, OP_RESP});
         chk("rst_pre_D1", {16'd0, D1}, 32'h0000_9876);
      end
      reset = 1'b1;
      exp_q.delete();
      model_req = 0;
      model_rd = 0;
      #1;
      chk("rst_core_req", {31'd0, core_req}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_C1", {29'd0, C1}, 32'd0);
      chk("rst_D1", {16'd0, D1}, 32'h0000_FFFF);
      chk("rst_core_addr", {13'd0, core_addr}, 32'd0);
      @(negedge clk); #1;
      reset = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  c_cmd;
      logic [18:0] c_addr;
      logic [31:0] c_wd;
      logic [15:0] b1, b2;
      int          nr;
      logic        bend;

      // Reset state
      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_core_req", {31'd0, core_req}, 32'd0);
      chk("reset_core_cmd", {29'd0, core_cmd}, 32'd0);
      chk("reset_core_addr", {13'd0, core_addr}, 32'd0);
      chk("reset_core_wdata", core_wdata, 32'd0);
      chk("reset_C1", {29'd0, C1}, 32'd0);
      chk("reset_D1", {16'd0, D1}, 32'h0000_FFFF);
      reset = 1'b0;
      mon_en = 1'b1;
      @(negedge clk); #1;

      // Three reads then one write
      run_txn(OP_READ8,  15'h0001, 15'h0001, 16'h0, 16'h0, 32'h0000_0011, 0, c_cmd, c_addr, c_wd, b1, b2, nr, bend);
      run_txn(OP_READ16, 15'h0002, 15'h0002, 16'h0, 16'h0, 32'h0000_2222, 1, c_cmd, c_addr, c_wd, b1, b2, nr, bend);
      run_txn(OP_READ32, 15'h0003, 15'h0003, 16'h0, 16'h0, 32'h3333_3333, 2, c_cmd, c_addr, c_wd, b1, b2, nr, bend);
      run_txn(OP_WR16,   15'h0004, 15'h0004, 16'h4444, 16'h0, 32'h0, 0, c_cmd, c_addr, c_wd, b1, b2, nr, bend);
`ifdef CACHE_C1_PORT_STATS_EN
      chk("stats_req_cnt", req_cnt, 32'd4);
      chk("stats_rd_cnt", rd_cnt, 32'd3);
`endif

      // READ32 at 1337/8, ack after 3 waiting cycles
      run_txn(OP_READ32, 15'd1337, 15'd8, 16'h0, 16'h0, 32'hDEAD_BEEF, 3, c_cmd, c_addr, c_wd, b1, b2, nr, bend);
      chk("r32_addr", {13'd0, c_addr}, 32'h0000_5398);
      chk("r32_cmd", {29'd0, c_cmd}, 32'd3);
      chk("r32_resp_cycles", nr, 32'd2);
      chk("r32_beat1", {16'd0, b1}, 32'h0000_BEEF);
      chk("r32_beat2", {16'd0, b2}, 32'h0000_DEAD);
      chk("r32_busy_end", {31'd0, bend}, 32'd0);

      // WRITE16
      run_txn(OP_WR16, 15'h0010, 15'h0003, 16'hA5A5, 16'h5A5A, 32'h0, 1, c_cmd, c_addr, c_wd, b1, b2, nr, bend);
      chk("w16_cmd", {29'd0, c_cmd}, 32'd6);
      chk("w16_wdata_lo", {16'd0, c_wd[15:0]}, 32'h0000_A5A5);
      chk("w16_resp_cycles", nr, 32'd1);
      chk("w16_D1_released", {16'd0, b1}, 32'h0000_FFFF);

      // WRITE32
      run_txn(OP_WR32, 15'h0100, 15'h0002, 16'h1111, 16'h2222, 32'h0, 0, c_cmd, c_addr, c_wd, b1, b2, nr, bend);
      chk("w32_wdata", c_wd, 32'h2222_1111);
      chk("w32_resp_cycles", nr, 32'd1);

      // READ8
      run_txn(OP_READ8, 15'h0200, 15'h0007, 16'h0, 16'h0, 32'h0000_00C3, 2, c_cmd, c_addr, c_wd, b1, b2, nr, bend);
      chk("r8_beat", {16'd0, b1}, 32'h0000_00C3);
      chk("r8_resp_cycles", nr, 32'd1);

      // Reset while waiting on the core, then a normal INVALIDATE
      reset_txn(1'b0);
      run_txn(OP_INVAL, 15'h0055, 15'h000A, 16'h0, 16'h0, 32'h0, 1, c_cmd, c_addr, c_wd, b1, b2, nr, bend);
      chk("inv_cmd", {29'd0, c_cmd}, 32'd4);
      chk("inv_resp_cycles", nr, 32'd1);
      chk("inv_busy_end", {31'd0, bend}, 32'd0);

      // Reset while the response is on the bus
      reset_txn(1'b1);

      // Randomized traffic
      for (int t = 0; t < 150; t++) begin
         run_txn(3'($urandom_range(1, 7)), 15'($urandom), 15'($urandom), 16'($urandom), 16'($urandom),
                 $urandom, $urandom_range(0, 4), c_cmd, c_addr, c_wd, b1, b2, nr, bend);
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk); #1;
            A1 = 15'($urandom);
         end
      end

`ifdef CACHE_C1_PORT_STATS_EN
      chk("final_req_cnt", req_cnt, 32'(model_req));
      chk("final_rd_cnt", rd_cnt, 32'(model_rd));
`endif
      @(negedge clk); #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
